// File: rtl/uart_core_if.sv
// rtl/uart_core_if.sv - RAM port-2 bus between uart_core and the shared data RAM
// Signals:
//   rramdata    RAM  -> uart  32  asynchronous read data of ramaddress
//   wram        uart -> RAM   1   write enable, one-cycle pulse
//   ramaddress  uart -> RAM   32  byte address
//   wramdata    uart -> RAM   32  write data
// Modports: master (uart_core side), slave (RAM side).
interface uart_core_if;
  logic [31:0] rramdata;
  logic        wram;
  logic [31:0] ramaddress;
  logic [31:0] wramdata;

  modport master (input rramdata, output wram, output ramaddress, output wramdata);
  modport slave  (output rramdata, input wram, input ramaddress, input wramdata);
endinterface

// File: rtl/uart_core.sv
// rtl/uart_core.sv - bit-serial UART bridge between a serial line and a word-wide RAM buffer
// Receive packs bytes from datai into 32-bit words written to BASE_ADDR+4+4k; a control
// word of exactly 1 at BASE_ADDR sends the whole buffer on datao, then clears the command.
// Frame: start 0, 8 data bits MSB first, stop 1. Optional macro UART_PARITY_EN inserts an
// even-parity bit after data bit 0 (11-bit frame); a parity mismatch on RX drops the byte.
// Ports:
//   clk    in   1   clock, rising edge
//   nrst   in   1   synchronous active-high reset
//   datai  in   1   serial RX line, idle high
//   datao  out  1   serial TX line, idle high
//   ram    uart_core_if.master  RAM port 2 (rramdata, wram, ramaddress, wramdata)
module uart_core #(
  parameter logic [31:0] BASE_ADDR    = 32'h0007_0000,
  parameter int          CLKS_PER_BIT = 1,
  parameter int          BUF_WORDS    = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        datai,
  output logic        datao,
  uart_core_if.master ram
);

`ifdef UART_PARITY_EN
  localparam int       FRAME_BITS = 11;
  localparam bit [3:0] PAR_BIT    = 4'd9;
`else
  localparam int       FRAME_BITS = 10;
`endif
  localparam int           CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int           IW       = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
  localparam bit [3:0]     STOP_BIT = 4'(FRAME_BITS - 1);
  localparam bit [CW-1:0]  CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam bit [IW-1:0]  IDX_LAST = IW'(BUF_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RECV, SEND, POST} state_t;

  state_t        state_q, state_d;
  logic          hold_q, hold_d;          // waiting for the line to go high after a bad frame
  logic [CW-1:0] rx_clk_q, rx_clk_d;
  logic [3:0]    rx_bit_q, rx_bit_d;      // 0 start, 1..8 data, then parity/stop
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [23:0]   acc_q, acc_d;            // earlier bytes of the current word
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [IW-1:0] rx_idx_q, rx_idx_d;
  logic [IW-1:0] tx_word_q, tx_word_d;
  logic [1:0]    tx_byte_q, tx_byte_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_clk_q, tx_clk_d;
`ifdef UART_PARITY_EN
  logic          rx_par_q, rx_par_d;
`endif

  logic [31:0] rx_addr, tx_addr;
  logic [7:0]  tx_cur_byte;
  logic        tx_bit_val;
  logic        rx_good;
  logic        rx_last, tx_last;

  assign rx_addr = BASE_ADDR + 32'd4 + (32'(rx_idx_q) << 2);
  assign tx_addr = BASE_ADDR + 32'd4 + (32'(tx_word_q) << 2);
  assign rx_last = (rx_clk_q == CLK_LAST);
  assign tx_last = (tx_clk_q == CLK_LAST);

`ifdef UART_PARITY_EN
  assign rx_good = datai & ~(^{rx_shift_q, rx_par_q});
`else
  assign rx_good = datai;
`endif

  // The word being sent is read combinationally every SEND cycle.
  always_comb begin
    tx_cur_byte = ram.rramdata[31:24];
    case (tx_byte_q)
      2'd1:    tx_cur_byte = ram.rramdata[23:16];
      2'd2:    tx_cur_byte = ram.rramdata[15:8];
      2'd3:    tx_cur_byte = ram.rramdata[7:0];
      default: tx_cur_byte = ram.rramdata[31:24];
    endcase
  end

  always_comb begin
    tx_bit_val = 1'b1;
    if (tx_bit_q == 4'd0) begin
      tx_bit_val = 1'b0;
    end else if (tx_bit_q <= 4'd8) begin
      tx_bit_val = tx_cur_byte[3'(4'd8 - tx_bit_q)];
`ifdef UART_PARITY_EN
    end else if (tx_bit_q == PAR_BIT) begin
      tx_bit_val = ^tx_cur_byte;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    rx_clk_d       = rx_clk_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    acc_d          = acc_q;
    byte_cnt_d     = byte_cnt_q;
    rx_idx_d       = rx_idx_q;
    tx_word_d      = tx_word_q;
    tx_byte_d      = tx_byte_q;
    tx_bit_d       = tx_bit_q;
    tx_clk_d       = tx_clk_q;
`ifdef UART_PARITY_EN
    rx_par_d       = rx_par_q;
`endif
    datao          = 1'b1;
    ram.wram       = 1'b0;
    ram.ramaddress = BASE_ADDR;
    ram.wramdata   = 32'h0;

    case (state_q)
      IDLE: begin
        if (hold_q) begin
          if (datai) hold_d = 1'b0;
        end else if (!datai) begin
          state_d = RECV;
          // The first start-bit cycle is spent here; with one clock per bit the
          // start bit is already over, so RECV begins on data bit 1.
          rx_bit_d = (CLKS_PER_BIT == 1) ? 4'd1 : 4'd0;
          rx_clk_d = (CLKS_PER_BIT == 1) ? '0 : CW'(1);
        end else if (ram.rramdata == 32'd1) begin
          state_d   = SEND;
          tx_word_d = '0;
          tx_byte_d = 2'd0;
          tx_bit_d  = 4'd0;
          tx_clk_d  = '0;
        end
      end

      RECV: begin
        ram.ramaddress = rx_addr;
        if (rx_last) begin
          rx_clk_d = '0;
          rx_bit_d = rx_bit_q + 4'd1;
          if (rx_bit_q >= 4'd1 && rx_bit_q <= 4'd8) rx_shift_d = {rx_shift_q[6:0], datai};
`ifdef UART_PARITY_EN
          if (rx_bit_q == PAR_BIT) rx_par_d = datai;
`endif
          if (rx_bit_q == STOP_BIT) begin
            state_d = IDLE;
            if (rx_good) begin
              if (byte_cnt_q == 2'd3) begin
                ram.wram     = 1'b1;
                ram.wramdata = {acc_q, rx_shift_q};
                byte_cnt_d   = 2'd0;
                rx_idx_d     = (rx_idx_q == IDX_LAST) ? '0 : rx_idx_q + IW'(1);
              end else begin
                acc_d      = {acc_q[15:0], rx_shift_q};
                byte_cnt_d = byte_cnt_q + 2'd1;
              end
            end else begin
              hold_d = 1'b1;
            end
          end
        end else begin
          rx_clk_d = rx_clk_q + CW'(1);
        end
      end

      SEND: begin
        ram.ramaddress = tx_addr;
        datao          = tx_bit_val;
        if (tx_last) begin
          tx_clk_d = '0;
          if (tx_bit_q == STOP_BIT) begin
            tx_bit_d = 4'd0;
            if (tx_byte_q == 2'd3) begin
              tx_byte_d = 2'd0;
              if (tx_word_q == IDX_LAST) state_d = POST;
              else tx_word_d = tx_word_q + IW'(1);
            end else begin
              tx_byte_d = tx_byte_q + 2'd1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_clk_d = tx_clk_q + CW'(1);
        end
      end

      POST: begin
        ram.wram = 1'b1;
        rx_idx_d = '0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A reset cycle must never leave a write behind.
    if (nrst) ram.wram = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q    <= IDLE;
      hold_q     <= 1'b0;
      rx_clk_q   <= '0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h0;
      acc_q      <= 24'h0;
      byte_cnt_q <= 2'd0;
      rx_idx_q   <= '0;
      tx_word_q  <= '0;
      tx_byte_q  <= 2'd0;
      tx_bit_q   <= 4'd0;
      tx_clk_q   <= '0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rx_clk_q   <= rx_clk_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      acc_q      <= acc_d;
      byte_cnt_q <= byte_cnt_d;
      rx_idx_q   <= rx_idx_d;
      tx_word_q  <= tx_word_d;
      tx_byte_q  <= tx_byte_d;
      tx_bit_q   <= tx_bit_d;
      tx_clk_q   <= tx_clk_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - self-checking bench for uart_core with a RAM model and a byte-level reference
module tb_uart_core;
  localparam logic [31:0] BASE = 32'h0007_0000;
  localparam int CPB = 1;
  localparam int BW  = 2;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int TXL = BW * 4 * FB * CPB;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] ctrl; bit sends; } ctrl_vec_t;

  logic clk = 1'b0;
  logic nrst;
  logic datai;
  logic datao;

  uart_core_if ram_if ();

  uart_core #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .BUF_WORDS(BW)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .datai (datai),
    .datao (datao),
    .ram   (ram_if)
  );

  always #5 clk = ~clk;

  // Shared RAM: port 1 is the bench acting as CPU, port 2 is the DUT.
  logic [31:0] mem [0:BW];
  logic        cpu_we;
  int          cpu_idx;
  logic [31:0] cpu_data;
  wr_t         wr_log [0:255];
  int          wr_cnt = 0;
  logic [31:0] ram_off;
  logic        ram_hit;
  int          ram_idx;

  assign ram_off = ram_if.ramaddress - BASE;
  assign ram_idx = int'(ram_off >> 2);
  assign ram_hit = (ram_off[1:0] == 2'b00) && ((ram_off >> 2) <= 32'(BW));
  assign ram_if.rramdata = ram_hit ? mem[ram_idx] : 32'h0;

  always @(posedge clk) begin
    if (cpu_we) mem[cpu_idx] <= cpu_data;
    if (ram_if.wram) begin
      if (wr_cnt < 256) wr_log[wr_cnt] <= {ram_if.ramaddress, ram_if.wramdata};
      wr_cnt <= wr_cnt + 1;
      if (ram_hit) mem[ram_idx] <= ram_if.wramdata;
    end
  end

  // Reference model: bytes accepted off the line, words expected in the buffer.
  int          n_err = 0;
  int          n_chk = 0;
  int          wr_seen = 0;
  wr_t         exp_q [$];
  logic [7:0]  part [$];
  int          m_idx = 0;
  logic [31:0] model_mem [0:BW];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic cpu_write(input int idx, input logic [31:0] d);
    cpu_we = 1'b1; cpu_idx = idx; cpu_data = d; model_mem[idx] = d;
    cyc();
    cpu_we = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    part.push_back(b);
    if (part.size() == 4) begin
      w = {part[0], part[1], part[2], part[3]};
      exp_q.push_back({BASE + 32'd4 + 32'(4 * m_idx), w});
      model_mem[m_idx + 1] = w;
      m_idx = (m_idx + 1) % BW;
      part.delete();
    end
  endtask

  task automatic model_reset();
    part.delete();
    m_idx = 0;
  endtask

  task automatic put_bit(input logic v);
    datai = v;
    repeat (CPB) cyc();
  endtask

  task automatic gap(input int n);
    datai = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
    put_bit(1'b0);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
`ifdef UART_PARITY_EN
    put_bit((^b) ^ par_flip);
`endif
    put_bit(stop_ok);
    if (stop_ok && !par_flip) model_byte(b);
  endtask

  task automatic check_writes(input string tag);
    int n;
    n = wr_cnt - wr_seen;
    chk({tag, " write count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      chk($sformatf("%s write%0d addr", tag, i), wr_log[wr_seen + i].addr, exp_q[i].addr);
      chk($sformatf("%s write%0d data", tag, i), wr_log[wr_seen + i].data, exp_q[i].data);
    end
    wr_seen = wr_cnt;
    exp_q.delete();
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i <= BW; i++) chk($sformatf("%s mem[%0d]", tag, i), mem[i], model_mem[i]);
  endtask

  // Called one cycle after the command was written; captures and decodes the whole send.
  task automatic run_send(input string tag);
    int         lat;
    bit         cap [$];
    logic [7:0] b;
    logic [FB-1:0] got, expf;
    lat = 0;
    while (datao !== 1'b0 && lat < 8) begin
      cyc();
      lat++;
    end
    chk({tag, " start latency"}, lat, 1);
    for (int j = 0; j < TXL; j++) begin
      cap.push_back(datao);
      cyc();
    end
    chk({tag, " post wram"}, ram_if.wram, 1);
    chk({tag, " post addr"}, ram_if.ramaddress, BASE);
    chk({tag, " post data"}, ram_if.wramdata, 0);
    exp_q.push_back({BASE, 32'h0});
    for (int f = 0; f < BW * 4; f++) begin
      b = 8'(model_mem[1 + f / 4] >> (24 - 8 * (f % 4)));
      expf = '1;
      expf[0] = 1'b0;
      for (int i = 0; i < 8; i++) expf[1 + i] = b[7 - i];
`ifdef UART_PARITY_EN
      expf[9] = ^b;
`endif
      for (int k = 0; k < FB; k++) got[k] = cap[(f * FB + k) * CPB + CPB - 1];
      chk($sformatf("%s frame%0d", tag, f), 32'(got), 32'(expf));
    end
    model_mem[0] = 32'h0;
    m_idx = 0;
    cyc();
    chk({tag, " idle datao"}, datao, 1);
    chk({tag, " idle wram"}, ram_if.wram, 0);
    check_writes(tag);
    chk({tag, " cmd cleared"}, mem[0], 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_vec_t cv [6];
    int lows;
    logic [7:0] rb;
    bit bad, pf;

    cv[0] = '{32'h0000_0000, 1'b0};
    cv[1] = '{32'h0000_0002, 1'b0};
    cv[2] = '{32'h0000_0003, 1'b0};
    cv[3] = '{32'hFFFF_FFFF, 1'b0};
    cv[4] = '{32'h0001_0001, 1'b0};
    cv[5] = '{32'h0000_0001, 1'b1};

    nrst = 1'b1; datai = 1'b1; cpu_we = 1'b0; cpu_idx = 0; cpu_data = 32'h0;
    repeat (2) cyc();
    for (int i = 0; i <= BW; i++) cpu_write(i, 32'h0);

    // Reset state and quiet line.
    chk("reset datao", datao, 1);
    chk("reset wram", ram_if.wram, 0);
    chk("reset addr", ram_if.ramaddress, BASE);
    chk("reset wdata", ram_if.wramdata, 0);
    nrst = 1'b0;
    repeat (10) cyc();
    check_writes("idle");

    // Eight 0xF0 frames back to back fill both buffer words.
    for (int i = 0; i < 8; i++) send_frame(8'hF0, 1'b1, 1'b0);
    gap(2);
    check_writes("rx8");
    check_mem("rx8");

    // Command send of the buffer.
    cpu_write(0, 32'h1);
    run_send("tx");

    // Framing error drops the byte; following four bytes form one word.
    send_frame(8'h3C, 1'b0, 1'b0);
    gap(2);
    check_writes("framing");
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    gap(2);
    check_writes("after framing");

    // Reset after two bytes and mid-way through a third frame.
    send_frame(8'hAA, 1'b1, 1'b0);
    send_frame(8'hBB, 1'b1, 1'b0);
    put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    datai = 1'b1; nrst = 1'b1;
    cyc();
    nrst = 1'b0;
    model_reset();
    chk("rx reset datao", datao, 1);
    chk("rx reset wram", ram_if.wram, 0);
    gap(2);
    check_writes("rx reset");
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0);
    send_frame(8'h04, 1'b1, 1'b0);
    gap(2);
    check_writes("after rx reset");
    check_mem("after rx reset");

`ifdef UART_PARITY_EN
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1);
    gap(1);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    gap(2);
    check_writes("parity");
`endif

    // Control word table: only exactly 1 starts a send.
    for (int v = 0; v < 6; v++) begin
      cpu_write(0, cv[v].ctrl);
      if (cv[v].sends) begin
        run_send($sformatf("ctrl%0d", v));
      end else begin
        lows = 0;
        repeat (6) begin
          if (datao !== 1'b1) lows++;
          cyc();
        end
        chk($sformatf("ctrl%0d line idle", v), lows, 0);
        cpu_write(0, 32'h0);
      end
    end
    check_writes("ctrl table");

    // Reset in the middle of a send: line idles at once, no POST write.
    cpu_write(0, 32'h1);
    repeat (6) cyc();
    nrst = 1'b1; cpu_we = 1'b1; cpu_idx = 0; cpu_data = 32'h0; model_mem[0] = 32'h0;
    cyc();
    nrst = 1'b0; cpu_we = 1'b0;
    model_reset();
    chk("tx reset datao", datao, 1);
    chk("tx reset wram", ram_if.wram, 0);
    lows = 0;
    repeat (6) begin
      if (datao !== 1'b1) lows++;
      cyc();
    end
    chk("tx reset line idle", lows, 0);
    check_writes("tx reset");

    // Randomized traffic against the byte-level model, each round followed by a send.
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 14; n++) begin
        rb  = 8'($urandom);
        bad = ($urandom_range(0, 5) == 0);
`ifdef UART_PARITY_EN
        pf  = ($urandom_range(0, 5) == 0);
`else
        pf  = 1'b0;
`endif
        send_frame(rb, !bad, pf);
        if (bad || pf) gap($urandom_range(1, 2));
        else gap($urandom_range(0, 2));
      end
      gap(2);
      check_writes($sformatf("rand%0d", r));
      check_mem($sformatf("rand%0d", r));
      cpu_write(0, 32'h1);
      run_send($sformatf("rand%0d tx", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
